pipeline_sink_fifo: RTL and testbench
=====================================

Name: pipeline_sink_fifo

Overview:
- Downstream consumer of the data pipeline's output stage.
- The pipeline has no backpressure: it presents a word plus a valid flag every cycle.
- This block absorbs that stream into a small first-word-fall-through (FWFT) FIFO and re-issues it on a valid/ready handshake towards the next consumer.
- Words that arrive while the FIFO is full are dropped and flagged.

Parameters:
- p_width, 32, data word width; must match the pipeline's data width.
- p_depth, 8, FIFO entries; power of two, at least 2.
- p_almost_full, 6, occupancy threshold for o_almost_full; 1 to p_depth. Used only with the optional feature.

Ports:
- i_clk  input  1  clock.
- i_rst  input  1  reset; asynchronous, active-high.
- i_valid  input  1  upstream word valid this cycle; no ready returned upstream.
- i_data  input  p_width  upstream pipeline output word.
- i_ready  input  1  downstream accepts o_data this cycle.
- i_clr_overflow  input  1  synchronous clear of o_overflow.
- o_valid  output  1  FIFO non-empty; o_data is valid.
- o_data  output  p_width  head-of-FIFO word.
- o_count  output  $clog2(p_depth+1)  current occupancy, 0 to p_depth.
- o_full  output  1  o_count == p_depth.
- o_overflow  output  1  sticky: at least one word was dropped.
- o_almost_full  output  1  present only with the optional feature.

Behaviour:
- Reset:
  - Read and write pointers 0, count 0, o_overflow 0.
  - Therefore o_valid 0, o_full 0, o_count 0, o_almost_full 0.
  - Storage array is not reset; o_data is don't-care while o_valid is 0.
  - Reset asserted mid-operation discards all contents immediately (asynchronous); no partial state survives.
- Push:
  - Condition: i_valid && (!o_full || pop).
  - Writes i_data at the write pointer, then increments it modulo p_depth.
- Pop:
  - Condition: o_valid && i_ready.
  - Increments the read pointer modulo p_depth.
- Latency: a word pushed in cycle N appears on o_data with o_valid high in cycle N+1. No same-cycle bypass from i_data to o_data.
- o_data: driven combinationally from the storage entry at the read pointer; held stable while o_valid && !i_ready.
- Count update:
  - push only: +1.
  - pop only: −1.
  - both or neither: unchanged.
- Full with simultaneous push and pop: push accepted, count stays p_depth, no overflow.
- Drop:
  - Condition: i_valid && o_full && !pop.
  - The word is discarded, storage and pointers are unchanged, and o_overflow is set from the next cycle.
- o_overflow clear:
  - Cleared only by reset or by i_clr_overflow.
  - If a clear and a drop occur in the same cycle, the drop wins and o_overflow stays 1.
- Empty: i_ready is ignored while o_valid is 0; the pointers do not move.
- Wrap-around: pointers are $clog2(p_depth) bits and wrap naturally. Full and empty are derived from the count, not from pointer comparison.
- Output registration: o_valid, o_full, o_count and o_overflow are registered-state derived; no combinational path from i_valid or i_ready to these outputs.

Optional Feature:
- Macro: PIPELINE_SINK_FIFO_ALMOST_FULL_EN.
- Defined:
  - o_almost_full port exists.
  - o_almost_full = (o_count >= p_almost_full), derived from registered count.
  - Elaboration error if p_almost_full is 0 or greater than p_depth.
- Undefined:
  - Port absent and p_almost_full unused.
  - All other behaviour identical.

Decomposition:
- Package pipeline_sink_pkg:
  - Count-width and pointer-width constant functions.
  - Default width/depth localparams shared with the pipeline instance.
- One sub-module, pipeline_sink_ram:
  - p_depth x p_width storage.
  - Synchronous write port, asynchronous read port, no reset.
- pipeline_sink_fifo holds the pointers, count, flags and handshake logic.

Test Plan (p_width=32, p_depth=8, p_almost_full=6):
1. Reset then idle -> o_valid=0, o_count=0, o_full=0, o_overflow=0; i_ready toggling causes no change.
2. Push 0x11 at cycle 0, i_ready=0 -> o_valid=1 and o_data=0x11 at cycle 1; o_data held for 5 cycles; pop at cycle 6 -> o_valid=0 at cycle 7.
3. Push 0x1..0xA on 10 consecutive cycles with i_ready=0:
   - o_full=1 after 8 pushes; 0x9 and 0xA are dropped; o_overflow=1.
   - Draining yields exactly 0x1..0x8 in order.
4. Fill to 8, then push and pop every cycle for 20 cycles -> count stays 8, o_overflow stays 0, output order strictly sequential across pointer wrap.
5. With the FIFO full, i_clr_overflow and a dropped push in the same cycle -> o_overflow stays 1; clear alone next cycle -> o_overflow=0.
6. Assert i_rst asynchronously (mid-clock) at count 5 -> o_valid, o_count and o_overflow are 0 before the next edge. With the macro defined, o_almost_full rises when count goes 5→6 and falls when it goes 6→5.

Source files
------------

// File: rtl/pipeline_sink_pkg.sv
// Shared sizing helpers and default geometry for the pipeline sink FIFO.
package pipeline_sink_pkg;

  localparam int DEFAULT_WIDTH       = 32;
  localparam int DEFAULT_DEPTH       = 8;
  localparam int DEFAULT_ALMOST_FULL = 6;

  // Occupancy must represent 0..depth inclusive, hence depth+1 states.
  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int ptr_width(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/pipeline_sink_ram.sv
// FIFO storage: synchronous write, asynchronous read, contents never reset.
module pipeline_sink_ram
  import pipeline_sink_pkg::*;
#(
  parameter int p_width = DEFAULT_WIDTH,
  parameter int p_depth = DEFAULT_DEPTH
) (
  input  logic                          i_clk,
  input  logic                          i_we,
  input  logic [ptr_width(p_depth)-1:0] i_waddr,
  input  logic [p_width-1:0]            i_wdata,
  input  logic [ptr_width(p_depth)-1:0] i_raddr,
  output logic [p_width-1:0]            o_rdata
);

  logic [p_width-1:0] mem [p_depth];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = mem[i_raddr];

endmodule

// File: rtl/pipeline_sink_fifo.sv
// FWFT sink FIFO absorbing a no-backpressure pipeline stream; drops and flags words when full.
// Optional o_almost_full output enabled by defining PIPELINE_SINK_FIFO_ALMOST_FULL_EN.
module pipeline_sink_fifo
  import pipeline_sink_pkg::*;
#(
  parameter int p_width       = DEFAULT_WIDTH,
  parameter int p_depth       = DEFAULT_DEPTH,
  parameter int p_almost_full = DEFAULT_ALMOST_FULL
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic                            i_valid,
  input  logic [p_width-1:0]              i_data,
  input  logic                            i_ready,
  input  logic                            i_clr_overflow,
  output logic                            o_valid,
  output logic [p_width-1:0]              o_data,
  output logic [count_width(p_depth)-1:0] o_count,
  output logic                            o_full,
  output logic                            o_overflow
`ifdef PIPELINE_SINK_FIFO_ALMOST_FULL_EN
  ,
  output logic                            o_almost_full
`endif
);

  localparam int PTR_W = ptr_width(p_depth);
  localparam int CNT_W = count_width(p_depth);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(p_depth);

  if (p_depth < 2 || (p_depth & (p_depth - 1)) != 0) begin : g_bad_depth
    $error("pipeline_sink_fifo: p_depth must be a power of two and at least 2");
  end

  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic             overflow;
  logic             empty;
  logic             full;
  logic             pop;
  logic             push;
  logic             drop;

  // Flags come from the registered count only, so no input reaches them combinationally.
  assign empty = (count == '0);
  assign full  = (count == CNT_FULL);

  // A pop frees a slot in the same cycle, so a full FIFO still accepts when draining.
  assign pop  = !empty && i_ready;
  assign push = i_valid && (!full || pop);
  assign drop = i_valid && full && !pop;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      if (push && !pop) begin
        count <= count + CNT_ONE;
      end else if (pop && !push) begin
        count <= count - CNT_ONE;
      end
      // A drop in the same cycle as a clear keeps the flag set.
      if (drop) begin
        overflow <= 1'b1;
      end else if (i_clr_overflow) begin
        overflow <= 1'b0;
      end
    end
  end

  pipeline_sink_ram #(
    .p_width (p_width),
    .p_depth (p_depth)
  ) u_ram (
    .i_clk   (i_clk),
    .i_we    (push),
    .i_waddr (wr_ptr),
    .i_wdata (i_data),
    .i_raddr (rd_ptr),
    .o_rdata (o_data)
  );

  assign o_valid    = !empty;
  assign o_full     = full;
  assign o_count    = count;
  assign o_overflow = overflow;

`ifdef PIPELINE_SINK_FIFO_ALMOST_FULL_EN
  if (p_almost_full < 1 || p_almost_full > p_depth) begin : g_bad_almost_full
    $error("pipeline_sink_fifo: p_almost_full must be in 1..p_depth");
  end

  localparam logic [CNT_W-1:0] CNT_ALMOST_FULL = CNT_W'(p_almost_full);

  assign o_almost_full = (count >= CNT_ALMOST_FULL);
`else
  localparam int unused_almost_full = p_almost_full;
`endif

endmodule

// File: tb/tb_pipeline_sink_fifo.sv
// Randomized and directed self-checking bench for pipeline_sink_fifo against a queue model.
module tb_pipeline_sink_fifo;

  localparam int W  = 32;
  localparam int D  = 8;
  localparam int AF = 6;
  localparam int CW = $clog2(D + 1);

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b0;
  logic          i_valid = 1'b0;
  logic [W-1:0]  i_data = '0;
  logic          i_ready = 1'b0;
  logic          i_clr_overflow = 1'b0;
  logic          o_valid;
  logic [W-1:0]  o_data;
  logic [CW-1:0] o_count;
  logic          o_full;
  logic          o_overflow;
`ifdef PIPELINE_SINK_FIFO_ALMOST_FULL_EN
  logic          o_almost_full;
`endif

  always #5 i_clk = ~i_clk;

  pipeline_sink_fifo #(
    .p_width       (W),
    .p_depth       (D),
    .p_almost_full (AF)
  ) dut (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_valid        (i_valid),
    .i_data         (i_data),
    .i_ready        (i_ready),
    .i_clr_overflow (i_clr_overflow),
    .o_valid        (o_valid),
    .o_data         (o_data),
    .o_count        (o_count),
    .o_full         (o_full),
    .o_overflow     (o_overflow)
`ifdef PIPELINE_SINK_FIFO_ALMOST_FULL_EN
    ,
    .o_almost_full  (o_almost_full)
`endif
  );

  int checks = 0;
  int errors = 0;

  logic [W-1:0] mq[$];
  bit           m_ovf = 1'b0;

  // Apply inputs for one clock, advance the model, return 1 time unit after the edge.
  task automatic drive(input bit v, input logic [W-1:0] d, input bit r, input bit c);
    bit m_pop, m_full, m_push, m_drop;
    i_valid = v;
    i_data = d;
    i_ready = r;
    i_clr_overflow = c;
    m_pop  = (mq.size() > 0) && r;
    m_full = (mq.size() == D);
    m_push = v && (!m_full || m_pop);
    m_drop = v && m_full && !m_pop;
    @(posedge i_clk);
    if (m_pop) void'(mq.pop_front());
    if (m_push) mq.push_back(d);
    if (m_drop) m_ovf = 1'b1;
    else if (c) m_ovf = 1'b0;
    #1;
  endtask

  task automatic do_reset();
    i_valid = 1'b0;
    i_ready = 1'b0;
    i_clr_overflow = 1'b0;
    i_rst = 1'b1;
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    mq.delete();
    m_ovf = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (o_valid !== 1'b0 || o_count !== '0 || o_full !== 1'b0 || o_overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: valid=%b count=%0d full=%b ovf=%b, required 0/0/0/0",
               o_valid, o_count, o_full, o_overflow);
    end
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, '0, i[0], 1'b0);
      checks++;
      if (o_valid !== 1'b0 || o_count !== '0) begin
        errors++;
        $display("FAIL idle_ready_toggle: cycle %0d valid=%b count=%0d, required 0/0",
                 i, o_valid, o_count);
      end
    end
  endtask

  task automatic test_latency_hold();
    do_reset();
    i_valid = 1'b1;
    i_data = 32'h11;
    #1;
    checks++;
    if (o_valid !== 1'b0) begin
      errors++;
      $display("FAIL no_bypass: valid=%b before edge, required 0", o_valid);
    end
    drive(1'b1, 32'h11, 1'b0, 1'b0);
    checks++;
    if (o_valid !== 1'b1 || o_data !== 32'h11) begin
      errors++;
      $display("FAIL first_word_latency: valid=%b data=%h, required 1/00000011", o_valid, o_data);
    end
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 32'hdead_beef, 1'b0, 1'b0);
      checks++;
      if (o_valid !== 1'b1 || o_data !== 32'h11) begin
        errors++;
        $display("FAIL hold_stable: cycle %0d valid=%b data=%h, required 1/00000011",
                 i, o_valid, o_data);
      end
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    checks++;
    if (o_valid !== 1'b0 || o_count !== '0) begin
      errors++;
      $display("FAIL pop_to_empty: valid=%b count=%0d, required 0/0", o_valid, o_count);
    end
  endtask

  task automatic test_overflow_drop();
    do_reset();
    for (int i = 1; i <= 10; i++) begin
      drive(1'b1, W'(i), 1'b0, 1'b0);
      if (i == 8) begin
        checks++;
        if (o_full !== 1'b1 || o_overflow !== 1'b0 || o_count !== CW'(8)) begin
          errors++;
          $display("FAIL fill_to_full: full=%b ovf=%b count=%0d, required 1/0/8",
                   o_full, o_overflow, o_count);
        end
      end
    end
    checks++;
    if (o_overflow !== 1'b1 || o_count !== CW'(8)) begin
      errors++;
      $display("FAIL drop_flag: ovf=%b count=%0d, required 1/8", o_overflow, o_count);
    end
    for (int k = 1; k <= 8; k++) begin
      checks++;
      if (o_valid !== 1'b1 || o_data !== W'(k)) begin
        errors++;
        $display("FAIL drain_order: slot %0d valid=%b data=%h, required 1/%h", k, o_valid, o_data, W'(k));
      end
      drive(1'b0, '0, 1'b1, 1'b0);
    end
    checks++;
    if (o_valid !== 1'b0 || o_overflow !== 1'b1) begin
      errors++;
      $display("FAIL drained_empty: valid=%b ovf=%b, required 0/1", o_valid, o_overflow);
    end
  endtask

  task automatic test_full_throughput();
    int exp_val;
    do_reset();
    for (int i = 0; i < D; i++) drive(1'b1, W'(100 + i), 1'b0, 1'b0);
    exp_val = 100;
    for (int i = 0; i < 20; i++) begin
      checks++;
      if (o_data !== W'(exp_val) || o_count !== CW'(8) || o_overflow !== 1'b0) begin
        errors++;
        $display("FAIL full_push_pop: cycle %0d data=%h count=%0d ovf=%b, required %h/8/0",
                 i, o_data, o_count, o_overflow, W'(exp_val));
      end
      drive(1'b1, W'(100 + D + i), 1'b1, 1'b0);
      exp_val++;
    end
    checks++;
    if (o_count !== CW'(8) || o_full !== 1'b1 || o_data !== W'(exp_val)) begin
      errors++;
      $display("FAIL after_wrap: count=%0d full=%b data=%h, required 8/1/%h",
               o_count, o_full, o_data, W'(exp_val));
    end
  endtask

  task automatic test_clr_vs_drop();
    drive(1'b1, 32'h5555_aaaa, 1'b0, 1'b1);
    checks++;
    if (o_overflow !== 1'b1) begin
      errors++;
      $display("FAIL drop_beats_clear: ovf=%b, required 1", o_overflow);
    end
    drive(1'b0, '0, 1'b0, 1'b1);
    checks++;
    if (o_overflow !== 1'b0 || o_count !== CW'(8)) begin
      errors++;
      $display("FAIL clear_alone: ovf=%b count=%0d, required 0/8", o_overflow, o_count);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < D + 1; i++) drive(1'b1, W'(200 + i), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b0, '0, 1'b1, 1'b0);
`ifdef PIPELINE_SINK_FIFO_ALMOST_FULL_EN
    checks++;
    if (o_almost_full !== 1'b0 || o_count !== CW'(5)) begin
      errors++;
      $display("FAIL almost_full_fall: af=%b count=%0d, required 0/5", o_almost_full, o_count);
    end
    drive(1'b1, 32'h77, 1'b0, 1'b0);
    checks++;
    if (o_almost_full !== 1'b1 || o_count !== CW'(6)) begin
      errors++;
      $display("FAIL almost_full_rise: af=%b count=%0d, required 1/6", o_almost_full, o_count);
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    checks++;
    if (o_almost_full !== 1'b0) begin
      errors++;
      $display("FAIL almost_full_fall_6_5: af=%b, required 0", o_almost_full);
    end
`endif
    checks++;
    if (o_count !== CW'(5) || o_overflow !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_state: count=%0d ovf=%b, required 5/1", o_count, o_overflow);
    end
    #2;
    i_rst = 1'b1;
    #1;
    checks++;
    if (o_valid !== 1'b0 || o_count !== '0 || o_overflow !== 1'b0 || o_full !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: valid=%b count=%0d ovf=%b full=%b, required 0/0/0/0",
               o_valid, o_count, o_overflow, o_full);
    end
    @(negedge i_clk);
    i_rst = 1'b0;
    mq.delete();
    m_ovf = 1'b0;
  endtask

  task automatic test_random();
    int bad;
    bit v, r, c;
    do_reset();
    bad = 0;
    for (int i = 0; i < 400; i++) begin
      v = ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 2) == 0);
      c = ($urandom_range(0, 15) == 0);
      drive(v, W'($urandom), r, c);
      checks++;
      if (o_valid !== (mq.size() != 0) || int'(o_count) != mq.size() ||
          o_full !== (mq.size() == D) || o_overflow !== m_ovf ||
          (mq.size() != 0 && o_data !== mq[0])) begin
        errors++;
        bad++;
        if (bad <= 5)
          $display("FAIL random_cycle_%0d: valid=%b count=%0d full=%b ovf=%b data=%h, required count=%0d ovf=%b head=%h",
                   i, o_valid, o_count, o_full, o_overflow, o_data, mq.size(), m_ovf,
                   (mq.size() != 0) ? mq[0] : '0);
      end
`ifdef PIPELINE_SINK_FIFO_ALMOST_FULL_EN
      checks++;
      if (o_almost_full !== (mq.size() >= AF)) begin
        errors++;
        $display("FAIL random_almost_full_%0d: af=%b count=%0d", i, o_almost_full, mq.size());
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_latency_hold();
    test_overflow_drop();
    test_full_throughput();
    test_clr_vs_drop();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
